// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   - funct3 encodings for load/store access size and sign
//   - stage state enum
//   - access_fault(): classifies an EX/MEM memory op as illegal or misaligned
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // True when the op must not reach memory: conflicting controls, an
    // unsupported funct3 for the direction, or a half/word that is not
    // naturally aligned. funct3[1:0] encodes the size for every legal code.
    function automatic logic access_fault(input logic       is_load,
                                          input logic       is_store,
                                          input logic [2:0] funct3,
                                          input logic [1:0] offset);
        logic bad_code;
        logic misaligned;
        if (is_load) begin
            bad_code = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end else begin
            bad_code = (funct3 > F3_W);
        end
        misaligned = ((funct3[1:0] == 2'b01) && offset[0]) ||
                     ((funct3[1:0] == 2'b10) && (offset != 2'b00));
        return (is_load && is_store) || bad_code || misaligned;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus.
//   master (MEM stage): mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata out;
//                       mem_ack, mem_rdata in
//   slave  (memory)   : the reverse
// mem_req is held until the cycle mem_ack is high; mem_rdata is valid with mem_ack.
interface mem_access_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_access_stage_load_extend.sv
// Load lane selection and extension (combinational).
//   rdata    : 32-bit word returned by memory
//   offset   : byte offset of the access within the word
//   funct3   : access size/sign
//   ext_data : value to write back
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] ext_data
);

    logic [31:0] byte_shift;
    logic [31:0] half_shift;

    // Bring the addressed lane down to bit 0.
    assign byte_shift = rdata >> {offset, 3'b000};
    assign half_shift = rdata >> {offset[1], 4'b0000};

    always_comb begin
        case (funct3)
            F3_B:    ext_data = {{24{byte_shift[7]}}, byte_shift[7:0]};
            F3_H:    ext_data = {{16{half_shift[15]}}, half_shift[15:0]};
            F3_BU:   ext_data = {24'h000000, byte_shift[7:0]};
            F3_HU:   ext_data = {16'h0000, half_shift[15:0]};
            default: ext_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the five-stage RISC-V pipeline.
// Issues loads/stores to a variable-latency memory over a req/ack bus,
// steers store lanes, extends load lanes, flags illegal/misaligned accesses
// and registers the MEM/WB outputs.
//   clk, rst          : clock, asynchronous active-low reset
//   ex_*              : EX/MEM latch contents (held by stall while busy)
//   stall             : combinational freeze request for upstream stages
//   mem               : memory bus (master side)
//   wb_*              : registered MEM/WB outputs
//   mem_fault         : one-cycle pulse when a faulting access retires
module mem_access_stage
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_memRead,
    input  logic        ex_memWrite,
    input  logic        ex_regWrite,
    input  logic        ex_memtoReg,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_aluOut,
    input  logic [31:0] ex_storeData,
    input  logic [4:0]  ex_rd,
    output logic        stall,
    mem_access_stage_if.master mem,
    output logic        wb_valid,
    output logic        wb_regWrite,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        mem_fault
);

    state_t      state_reg;
    logic        mem_req_reg;
    logic        mem_we_reg;
    logic [31:0] mem_addr_reg;
    logic [3:0]  mem_wstrb_reg;
    logic [31:0] mem_wdata_reg;
    logic [4:0]  rd_reg;
    logic [2:0]  funct3_reg;
    logic [1:0]  off_reg;
    logic        wb_valid_reg;
    logic        wb_regwrite_reg;
    logic [4:0]  wb_rd_reg;
    logic [31:0] wb_data_reg;
    logic        mem_fault_reg;

    logic [1:0]  ex_off;
    logic        ex_is_mem;
    logic        ex_bad;
    logic        ex_accept;
    logic [3:0]  wstrb_next;
    logic [31:0] wdata_next;
    logic [31:0] load_data;

    // Loads always write back the memory value, so memtoReg carries no extra
    // information in this stage.
    logic unused_memtoreg;
    assign unused_memtoreg = ex_memtoReg;

    assign ex_off    = ex_aluOut[1:0];
    assign ex_is_mem = ex_memRead || ex_memWrite;
    assign ex_bad    = ex_valid && ex_is_mem &&
                       access_fault(ex_memRead, ex_memWrite, ex_funct3, ex_off);
    assign ex_accept = ex_valid && ex_is_mem && !ex_bad;

    // Upstream advances on the ack edge, so the op is consumed exactly once.
    always_comb begin
        if (state_reg == IDLE) begin
            stall = ex_accept;
        end else begin
            stall = !mem.mem_ack;
        end
    end

    // Store lane steering; loads leave every strobe low.
    always_comb begin
        wstrb_next = 4'b0000;
        wdata_next = 32'h0000_0000;
        if (ex_memWrite) begin
            case (ex_funct3[1:0])
                2'b00: begin
                    wstrb_next = 4'b0001 << ex_off;
                    wdata_next = {4{ex_storeData[7:0]}};
                end
                2'b01: begin
                    wstrb_next = 4'b0011 << ex_off;
                    wdata_next = {2{ex_storeData[15:0]}};
                end
                default: begin
                    wstrb_next = 4'b1111;
                    wdata_next = ex_storeData;
                end
            endcase
        end
    end

    load_extend u_load_extend (
        .rdata    (mem.mem_rdata),
        .offset   (off_reg),
        .funct3   (funct3_reg),
        .ext_data (load_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            mem_req_reg     <= 1'b0;
            mem_we_reg      <= 1'b0;
            mem_addr_reg    <= 32'h0000_0000;
            mem_wstrb_reg   <= 4'b0000;
            mem_wdata_reg   <= 32'h0000_0000;
            rd_reg          <= 5'd0;
            funct3_reg      <= 3'b000;
            off_reg         <= 2'b00;
            wb_valid_reg    <= 1'b0;
            wb_regwrite_reg <= 1'b0;
            wb_rd_reg       <= 5'd0;
            wb_data_reg     <= 32'h0000_0000;
            mem_fault_reg   <= 1'b0;
        end else begin
            mem_fault_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!ex_valid) begin
                        wb_valid_reg    <= 1'b0;
                        wb_regwrite_reg <= 1'b0;
                    end else if (ex_bad) begin
                        // Faulting op retires immediately without a write.
                        wb_valid_reg    <= 1'b1;
                        wb_regwrite_reg <= 1'b0;
                        wb_rd_reg       <= ex_rd;
                        mem_fault_reg   <= 1'b1;
                    end else if (ex_accept) begin
                        wb_valid_reg    <= 1'b0;
                        wb_regwrite_reg <= 1'b0;
                        mem_req_reg     <= 1'b1;
                        mem_we_reg      <= ex_memWrite;
                        mem_addr_reg    <= {ex_aluOut[31:2], 2'b00};
                        mem_wstrb_reg   <= wstrb_next;
                        mem_wdata_reg   <= wdata_next;
                        rd_reg          <= ex_rd;
                        funct3_reg      <= ex_funct3;
                        off_reg         <= ex_off;
                        state_reg       <= WAIT;
                    end else begin
                        wb_valid_reg    <= 1'b1;
                        wb_regwrite_reg <= ex_regWrite;
                        wb_rd_reg       <= ex_rd;
                        wb_data_reg     <= ex_aluOut;
                    end
                end
                WAIT: begin
                    if (mem.mem_ack) begin
                        mem_req_reg  <= 1'b0;
                        state_reg    <= IDLE;
                        wb_valid_reg <= 1'b1;
                        wb_rd_reg    <= rd_reg;
                        if (mem_we_reg) begin
                            wb_regwrite_reg <= 1'b0;
                        end else begin
                            wb_regwrite_reg <= 1'b1;
                            wb_data_reg     <= load_data;
                        end
                    end else begin
                        wb_valid_reg    <= 1'b0;
                        wb_regwrite_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mem.mem_req   = mem_req_reg;
    assign mem.mem_we    = mem_we_reg;
    assign mem.mem_addr  = mem_addr_reg;
    assign mem.mem_wstrb = mem_wstrb_reg;
    assign mem.mem_wdata = mem_wdata_reg;
    assign wb_valid      = wb_valid_reg;
    assign wb_regWrite   = wb_regwrite_reg;
    assign wb_rd         = wb_rd_reg;
    assign wb_data       = wb_data_reg;
    assign mem_fault     = mem_fault_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus randomized
// ops against a transaction-level model; outputs compared every cycle.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_memRead, ex_memWrite, ex_regWrite, ex_memtoReg;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_aluOut, ex_storeData;
    logic [4:0]  ex_rd;
    logic        stall, wb_valid, wb_regWrite, mem_fault;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    mem_access_stage_if mem_bus ();

    mem_access_stage dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_memRead   (ex_memRead),
        .ex_memWrite  (ex_memWrite),
        .ex_regWrite  (ex_regWrite),
        .ex_memtoReg  (ex_memtoReg),
        .ex_funct3    (ex_funct3),
        .ex_aluOut    (ex_aluOut),
        .ex_storeData (ex_storeData),
        .ex_rd        (ex_rd),
        .stall        (stall),
        .mem          (mem_bus),
        .wb_valid     (wb_valid),
        .wb_regWrite  (wb_regWrite),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .mem_fault    (mem_fault)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Expected values visible this cycle (exp_*) and after the coming edge (pend_*).
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_valid, exp_rw, exp_fault, exp_req, exp_we, exp_chk_data, exp_chk_wdata;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data, exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;
    logic        pend_valid, pend_rw, pend_fault, pend_req, pend_we, pend_chk_data, pend_chk_wdata;
    logic [4:0]  pend_rd;
    logic [31:0] pend_data, pend_addr, pend_wdata;
    logic [3:0]  pend_wstrb;

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] model_load(input logic [31:0] w, input int off, input int f3);
        logic [31:0] b = (w >> (8 * off)) & 32'hFF;
        logic [31:0] h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            4: return b;
            5: return h;
            default: return w;
        endcase
    endfunction

    function automatic logic model_fault(input logic r, input logic w, input int f3, input logic [31:0] alu);
        int size;
        if (r && w) return 1'b1;
        if (r && !(f3 inside {0, 1, 2, 4, 5})) return 1'b1;
        if (w && f3 > 2) return 1'b1;
        size = 1 << (f3 % 4);
        return (alu % size) != 0;
    endfunction

    function automatic logic [3:0] model_wstrb(input int f3, input int off);
        case (f3)
            0: return 4'(32'd1 << off);
            1: return 4'(32'd3 << off);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input int f3, input logic [31:0] d);
        case (f3)
            0: return (d & 32'hFF) * 32'h0101_0101;
            1: return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (chk_en) begin
                check("stall", 32'(stall), 32'(exp_stall));
                check("wb_valid", 32'(wb_valid), 32'(exp_valid));
                check("wb_regWrite", 32'(wb_regWrite), 32'(exp_rw));
                check("mem_fault", 32'(mem_fault), 32'(exp_fault));
                check("mem_req", 32'(mem_bus.mem_req), 32'(exp_req));
                if (exp_chk_data) begin
                    check("wb_rd", 32'(wb_rd), 32'(exp_rd));
                    check("wb_data", wb_data, exp_data);
                end
                if (exp_req) begin
                    check("mem_we", 32'(mem_bus.mem_we), 32'(exp_we));
                    check("mem_addr", mem_bus.mem_addr, exp_addr);
                    check("mem_wstrb", 32'(mem_bus.mem_wstrb), 32'(exp_wstrb));
                    if (exp_chk_wdata) check("mem_wdata", mem_bus.mem_wdata, exp_wdata);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic cycle();
        @(negedge clk);
        exp_valid = pend_valid; exp_rw = pend_rw; exp_fault = pend_fault; exp_req = pend_req;
        exp_we = pend_we; exp_rd = pend_rd; exp_data = pend_data; exp_addr = pend_addr;
        exp_wstrb = pend_wstrb; exp_wdata = pend_wdata;
        exp_chk_data = pend_chk_data; exp_chk_wdata = pend_chk_wdata;
        pend_fault = 1'b0;
    endtask

    task automatic reset_expect();
        exp_stall = 0; exp_valid = 0; exp_rw = 0; exp_fault = 0; exp_req = 0; exp_we = 0;
        exp_rd = 0; exp_data = 0; exp_addr = 0; exp_wstrb = 0; exp_wdata = 0;
        exp_chk_data = 1; exp_chk_wdata = 0;
        pend_valid = 0; pend_rw = 0; pend_fault = 0; pend_req = 0; pend_we = 0;
        pend_rd = 0; pend_data = 0; pend_addr = 0; pend_wstrb = 0; pend_wdata = 0;
        pend_chk_data = 1; pend_chk_wdata = 0;
    endtask

    task automatic op(input logic v, input logic r, input logic w, input logic rw,
                      input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] sd,
                      input logic [4:0] rd, input int lat, input logic [31:0] rdata);
        logic flt, legal;
        cycle();
        ex_valid = v; ex_memRead = r; ex_memWrite = w; ex_regWrite = rw; ex_memtoReg = r;
        ex_funct3 = f3; ex_aluOut = alu; ex_storeData = sd; ex_rd = rd;
        mem_bus.mem_ack = 1'($urandom);          // must be ignored outside WAIT
        mem_bus.mem_rdata = $urandom;
        flt = v && (r || w) && model_fault(r, w, int'(f3), alu);
        legal = v && (r || w) && !flt;
        exp_stall = legal;
        if (!legal) begin
            pend_req = 0; pend_chk_wdata = 0;
            if (!v) begin
                pend_valid = 0; pend_rw = 0; pend_chk_data = 0;
            end else if (flt) begin
                pend_valid = 1; pend_rw = 0; pend_fault = 1; pend_chk_data = 0;
            end else begin
                pend_valid = 1; pend_rw = rw; pend_rd = rd; pend_data = alu; pend_chk_data = 1;
            end
        end else begin
            pend_valid = 0; pend_rw = 0; pend_chk_data = 0;
            pend_req = 1; pend_we = w; pend_addr = alu & ~32'h3;
            pend_wstrb = w ? model_wstrb(int'(f3), int'(alu[1:0])) : 4'h0;
            pend_wdata = model_wdata(int'(f3), sd); pend_chk_wdata = w;
            for (int k = 1; k <= lat; k++) begin
                cycle();
                // Upstream garbage during WAIT must be ignored.
                ex_valid = 1'($urandom); ex_memRead = 1'($urandom); ex_memWrite = 1'($urandom);
                ex_regWrite = 1'($urandom); ex_funct3 = 3'($urandom); ex_aluOut = $urandom;
                ex_storeData = $urandom; ex_rd = 5'($urandom);
                mem_bus.mem_ack = (k == lat);
                mem_bus.mem_rdata = (k == lat) ? rdata : $urandom;
                exp_stall = (k != lat);
                if (k == lat) begin
                    pend_req = 0; pend_valid = 1; pend_rw = r; pend_rd = rd;
                    pend_data = model_load(rdata, int'(alu[1:0]), int'(f3));
                    pend_chk_data = r; pend_chk_wdata = 0;
                end
            end
        end
    endtask

    task automatic idle_lit(input string name, input logic [31:0] lit);
        op(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1, 32'd0);
        #2;
        check(name, wb_data, lit);
    endtask

    task automatic idle_fault(input string name, input logic lit);
        op(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1, 32'd0);
        #2;
        check(name, 32'(mem_fault), 32'(lit));
    endtask

    initial begin
        logic r, w;
        int kind;
        logic [2:0] f3;
        logic [31:0] alu;

        rst = 1'b0;
        ex_valid = 0; ex_memRead = 0; ex_memWrite = 0; ex_regWrite = 0; ex_memtoReg = 0;
        ex_funct3 = 0; ex_aluOut = 0; ex_storeData = 0; ex_rd = 0;
        mem_bus.mem_ack = 0; mem_bus.mem_rdata = 0;
        reset_expect();
        repeat (2) @(negedge clk);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_mem_req", 32'(mem_bus.mem_req), 32'd0);
        check("rst_mem_fault", 32'(mem_fault), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        rst = 1'b1;
        chk_en = 1'b1;

        // Pin the model against hand-computed values.
        check("model_lb", model_load(32'h80FF_7F01, 3, 0), 32'hFFFF_FF80);
        check("model_lbu", model_load(32'h80FF_7F01, 3, 4), 32'h0000_0080);
        check("model_sh_wstrb", 32'(model_wstrb(1, 2)), 32'h0000_000C);
        check("model_sh_wdata", model_wdata(1, 32'h1234_ABCD), 32'hABCD_ABCD);
        check("model_lw_mis", 32'(model_fault(1'b1, 1'b0, 2, 32'h3001)), 32'd1);

        // Directed cases.
        op(1, 0, 0, 1, 3'b000, 32'h0000_002A, 32'd0, 5'd5, 1, 32'd0);
        idle_lit("nonmem_data", 32'h0000_002A);
        op(1, 1, 0, 1, 3'b000, 32'h0000_1003, 32'd0, 5'd7, 3, 32'h80FF_7F01);
        idle_lit("lb_data", 32'hFFFF_FF80);
        op(1, 1, 0, 1, 3'b100, 32'h0000_1003, 32'd0, 5'd7, 3, 32'h80FF_7F01);
        idle_lit("lbu_data", 32'h0000_0080);
        op(1, 0, 1, 0, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 5'd3, 1, 32'd0);
        op(1, 1, 0, 1, 3'b010, 32'h0000_3001, 32'd0, 5'd4, 1, 32'd0);
        idle_fault("lw_mis_fault", 1'b1);
        idle_fault("lw_mis_fault_end", 1'b0);
        op(1, 1, 1, 1, 3'b010, 32'h0000_3000, 32'd0, 5'd4, 1, 32'd0);
        idle_fault("rw_both_fault", 1'b1);

        // Reset two cycles into a WAIT.
        cycle();
        ex_valid = 1; ex_memRead = 1; ex_memWrite = 0; ex_regWrite = 1; ex_funct3 = 3'b010;
        ex_aluOut = 32'h0000_5000; ex_rd = 5'd9; mem_bus.mem_ack = 0;
        exp_stall = 1;
        pend_valid = 0; pend_rw = 0; pend_chk_data = 0; pend_req = 1; pend_we = 0;
        pend_addr = 32'h0000_5000; pend_wstrb = 4'h0; pend_chk_wdata = 0;
        cycle(); mem_bus.mem_ack = 0; exp_stall = 1;
        cycle(); mem_bus.mem_ack = 0; exp_stall = 1;
        @(negedge clk);
        chk_en = 1'b0;
        rst = 1'b0;
        ex_valid = 0;
        #1;
        check("abort_mem_req", 32'(mem_bus.mem_req), 32'd0);
        check("abort_wb_valid", 32'(wb_valid), 32'd0);
        check("abort_wb_regWrite", 32'(wb_regWrite), 32'd0);
        check("abort_wb_rd", 32'(wb_rd), 32'd0);
        check("abort_wb_data", wb_data, 32'd0);
        check("abort_mem_addr", mem_bus.mem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        reset_expect();
        chk_en = 1'b1;
        op(1, 1, 0, 1, 3'b010, 32'h0000_4000, 32'd0, 5'd11, 2, 32'hDEAD_BEEF);
        idle_lit("lw_after_reset", 32'hDEAD_BEEF);

        // Randomized ops.
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 5);
            f3 = 3'($urandom);
            alu = $urandom;
            if ($urandom_range(0, 1) == 1) alu[1:0] = 2'b00;
            case (kind)
                0:       begin r = 1'($urandom); w = 1'($urandom); end
                1:       begin r = 0; w = 0; end
                2, 3:    begin r = 1; w = 0; end
                4:       begin r = 0; w = 1; end
                default: begin r = 1'($urandom); w = 1'($urandom); end
            endcase
            op(kind != 0, r, w, 1'($urandom), f3, alu, $urandom, 5'($urandom),
               $urandom_range(1, 4), $urandom);
        end
        op(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1, 32'd0);
        op(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1, 32'd0);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
